fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Next-generation instruction fetch front end between the PC/redirect logic and the instruction memory port.
- Owns the sequential fetch PC and issues pipelined req/rdy requests with up to MAX_OUTSTANDING in flight.
- Buffers in-order responses in a FIFO_DEPTH-entry {pc, instr} queue feeding decode with a valid/ready handshake.
- On redirect, discards in-flight and buffered instructions; replaces the single-request, stall-based fetcher.

Parameters:
XLEN, 32, address and instruction width
MAX_OUTSTANDING, 2, max accepted-but-unanswered IMEM requests (>=1)
FIFO_DEPTH, 4, instruction queue entries (>=2, power of two)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  branch/jump/exception redirect this cycle
redirect_pc  in  XLEN  new fetch address
imem_req  out  1  request to IMEM
imem_addr  out  XLEN  request address, word aligned
imem_rdy  in  1  IMEM accepts request (handshake = imem_req & imem_rdy)
imem_valid  in  1  one-cycle pulse per accepted request, in order
imem_rdata  in  XLEN  instruction data, qualified by imem_valid
ir_valid  out  1  instruction available to decode
ir  out  XLEN  instruction word
ir_pc  out  XLEN  address of ir
id_ready  in  1  decode consumes ir (pop = ir_valid & id_ready)
stall  out  1  equals !ir_valid; freezes downstream PC/decode

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, imem_req=0, outstanding=0, drop_cnt=0, FIFO empty, ir_valid=0, ir=0, ir_pc=0, stall=1.
- imem_addr = fetch_pc always; imem_req = !redirect_valid & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < FIFO_DEPTH). The credit rule guarantees no FIFO overflow.
- Accept: fetch_pc += 4 (mod 2^XLEN, wraps from 0xFFFF_FFFC to 0); outstanding += 1. Each accepted address is also pushed to an internal in-order PC tag queue.
- Holding rule: while imem_req=1 and imem_rdy=0, imem_addr stays stable. The request may only be withdrawn by redirect.
- Response: imem_valid decrements outstanding and pops the tag queue.
  - If drop_cnt>0: decrement drop_cnt, discard data.
  - Else: push {tag_pc, imem_rdata} into the FIFO.
- Same-cycle accept and response: outstanding is unchanged.
- Response with outstanding=0 is a protocol error: ignored, no state change.
- FIFO head drives ir/ir_pc; ir_valid = !empty. ir/ir_pc hold their last value when empty.
- Simultaneous push and pop is legal at any level, including full and empty. Push-only on empty gives ir_valid=1 the following cycle (1-cycle response-to-decode latency).
- Redirect (highest priority):
  - fetch_pc <= redirect_pc.
  - FIFO flushed; ir_valid=0 next cycle.
  - drop_cnt <= outstanding - (imem_valid this cycle).
  - Any pop in the same cycle is ignored.
  - imem_req is forced 0 in the redirect cycle, so no acceptance occurs then. The first request to redirect_pc issues the next cycle.
  - A second redirect while drop_cnt>0 accumulates: drop_cnt = total unanswered requests.
  - New requests may issue while drop_cnt>0, limited by MAX_OUTSTANDING counting dropped ones.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset release with outstanding=0 are ignored.
- Counter widths: $clog2(MAX_OUTSTANDING+1) and $clog2(FIFO_DEPTH+1); no arithmetic overflow permitted by construction.

Optional Feature:
FETCH_BYPASS_EN
- Defined:
  - When the FIFO is empty, drop_cnt=0 and imem_valid=1, ir_valid/ir/ir_pc are driven combinationally from the response in the same cycle.
  - If id_ready=1 that cycle, the word is consumed and not written to the FIFO; otherwise it is written normally.
  - Response-to-decode latency is 0.
- Undefined: all responses pass through the FIFO (latency 1). There is no combinational path from imem_* to ir_*.

Test Plan:
- Reset release, imem_rdy=1, 1-cycle memory, id_ready=1 -> addresses 0x0,0x4,0x8... back-to-back. ir_pc/ir sequence matches, stall=0 in steady state after the first instruction.
- imem_rdy=0 for 3 cycles with the request at 0x10 -> imem_addr held at 0x10, imem_req=1 throughout, fetch_pc advances to 0x14 only after the handshake.
- id_ready=0, MAX_OUTSTANDING=2, FIFO_DEPTH=4 -> exactly 4 requests accepted, then imem_req=0. FIFO full with 0x0..0xC and no overflow. Raising id_ready resumes requests.
- 2 requests outstanding (0x20,0x24), redirect to 0x100 -> both responses discarded, next ir_pc=0x100, no ir_valid between redirect and the 0x100 response.
- Redirect in the same cycle as the imem_valid for 0x20 with 0x24 outstanding -> drop_cnt=1, the 0x24 data is dropped, the 0x20 data is not enqueued.
- RESET_PC=32'hFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Async rst mid-stream clears ir_valid immediately.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Pipelined instruction fetch front end: owns the fetch PC, keeps up to MAX_OUTSTANDING IMEM requests
// in flight and queues in-order responses for decode. Optional macro FETCH_BYPASS_EN adds a 0-latency response bypass.
module fetch_prefetch_unit #(
    parameter int              XLEN            = 32,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              FIFO_DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rdy,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ir_valid,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    input  logic            id_ready,
    output logic            stall
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0] fetch_pc_q;
    logic [OW-1:0]   out_cnt_q;
    logic [OW-1:0]   drop_cnt_q;
    logic [TW-1:0]   tag_wr_q, tag_rd_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] ir_hold_q, ir_pc_hold_q;

    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [XLEN-1:0] fifo_ir [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];

    logic accept, resp, resp_keep, push, pop, fifo_empty;
    logic [XLEN-1:0] head_ir, head_pc;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign head_ir    = fifo_ir[rd_ptr_q];
    assign head_pc    = fifo_pc[rd_ptr_q];
    assign imem_addr  = fetch_pc_q;

    // Credits count dropped requests too, so the queue can never overflow.
    assign imem_req = rst & ~redirect_valid
                    & (int'(out_cnt_q) < MAX_OUTSTANDING)
                    & (int'(out_cnt_q) + int'(count_q) < FIFO_DEPTH);

    assign accept    = imem_req & imem_rdy;
    assign resp      = imem_valid & (out_cnt_q != '0);
    assign resp_keep = resp & (drop_cnt_q == '0) & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass   = resp_keep & fifo_empty;
    assign ir_valid = ~fifo_empty | bypass;
    assign ir       = ~fifo_empty ? head_ir : (bypass ? imem_rdata : ir_hold_q);
    assign ir_pc    = ~fifo_empty ? head_pc : (bypass ? tag_mem[tag_rd_q] : ir_pc_hold_q);
    assign push     = resp_keep & ~(bypass & id_ready);
    assign pop      = ~fifo_empty & id_ready & ~redirect_valid;
`else
    assign ir_valid = ~fifo_empty;
    assign ir       = fifo_empty ? ir_hold_q : head_ir;
    assign ir_pc    = fifo_empty ? ir_pc_hold_q : head_pc;
    assign push     = resp_keep;
    assign pop      = ~fifo_empty & id_ready & ~redirect_valid;
`endif

    assign stall = ~ir_valid;

    // NOTE: storage arrays carry no reset; validity is tracked by the reset counters and pointers.
    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wr_q] <= fetch_pc_q;
        if (push) begin
            fifo_ir[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q] <= tag_mem[tag_rd_q];
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            out_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            tag_wr_q     <= '0;
            tag_rd_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ir_hold_q    <= '0;
            ir_pc_hold_q <= '0;
        end else begin
            if (redirect_valid)  fetch_pc_q <= redirect_pc;
            else if (accept)     fetch_pc_q <= fetch_pc_q + XLEN'(4);

            out_cnt_q <= out_cnt_q + OW'(accept) - OW'(resp);

            // Everything still unanswered after this cycle belongs to the old stream.
            if (redirect_valid)                  drop_cnt_q <= out_cnt_q - OW'(resp);
            else if (resp && drop_cnt_q != '0)   drop_cnt_q <= drop_cnt_q - OW'(1);

            if (accept) tag_wr_q <= tag_inc(tag_wr_q);
            if (resp)   tag_rd_q <= tag_inc(tag_rd_q);

            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end

            if (ir_valid) begin
                ir_hold_q    <= ir;
                ir_pc_hold_q <= ir_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed vector table, hand-written redirect/stall
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_prefetch_unit;

    logic        clk, rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_rdy, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic        ir_valid, id_ready, stall;
    logic [31:0] ir, ir_pc;

    logic        u2_req, u2_ir_valid, u2_stall;
    logic [31:0] u2_addr, u2_ir, u2_ir_pc;

    fetch_prefetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
        .id_ready(id_ready), .stall(stall)
    );

    fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u2 (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(u2_req), .imem_addr(u2_addr), .imem_rdy(1'b1),
        .imem_valid(1'b0), .imem_rdata(32'h0),
        .ir_valid(u2_ir_valid), .ir(u2_ir), .ir_pc(u2_ir_pc),
        .id_ready(1'b1), .stall(u2_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit drop; } tag_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct {
        logic        rdy;
        logic        idr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    tag_t        mo[$];     // model: requests accepted and not yet answered
    ent_t        mf[$];     // model: instructions waiting for decode
    pend_t       pend[$];   // memory: accepted addresses awaiting their response
    logic [31:0] m_pc;
    bit          m_req;
    bit          spur;
    int          cyc, last_due, lat_min, lat_max;
    int          n_checks, n_fail;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        m_req = !redirect_valid && mo.size() < 2 && (mo.size() + mf.size()) < 4;
        check("imem_req", imem_req, m_req);
        check("imem_addr", imem_addr, m_pc);
        check("ir_valid", ir_valid, mf.size() > 0);
        check("stall", stall, mf.size() == 0);
        if (mf.size() > 0) begin
            check("ir_pc", ir_pc, mf[0].pc);
            check("ir", ir, mf[0].ins);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then compare against the model.
    task automatic apply(input bit rv, input logic [31:0] rpc, input bit rdy, input bit idr);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdy       = rdy;
        id_ready       = idr;
        if (spur) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = instr_of(pend[0].addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        model_check();
    endtask

    // Advance model and memory across the rising edge.
    task automatic finish();
        tag_t e;
        int   d;
        bit   resp, pop;
        resp = imem_valid && mo.size() > 0;
        pop  = !redirect_valid && mf.size() > 0 && id_ready;
        if (pop) void'(mf.pop_front());
        if (resp) begin
            e = mo.pop_front();
            if (!redirect_valid && !e.drop) mf.push_back('{pc: e.pc, ins: instr_of(e.pc)});
        end
        if (redirect_valid) begin
            mf.delete();
            foreach (mo[i]) mo[i].drop = 1'b1;
            m_pc = redirect_pc;
        end else if (m_req && imem_rdy) begin
            mo.push_back('{pc: m_pc, drop: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (imem_valid && !spur) void'(pend.pop_front());
        if (imem_req && imem_rdy) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: imem_addr, due: d});
        end
        spur = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rdy       = 1'b0;
        imem_valid     = 1'b0;
        imem_rdata     = 32'h0;
        id_ready       = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_ir_valid", ir_valid, 1'b0);
        check("rst_stall", stall, 1'b1);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_pc", ir_pc, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_u2_addr", u2_addr, 32'hFFFF_FFF8);
        mo.delete();
        mf.delete();
        pend.delete();
        m_pc     = 32'h0;
        spur     = 1'b0;
        last_due = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        last_due = cyc;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        logic [31:0] u2_exp[3];
        int          n_acc;
        bit          found;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 32'h4};
        u2_exp[0] = 32'hFFFF_FFF8;
        u2_exp[1] = 32'hFFFF_FFFC;
        u2_exp[2] = 32'h0000_0000;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat_min  = 1;
        lat_max  = 1;
        spur     = 1'b0;
        rst      = 1'b1;
        #2;
        do_reset();

        // Back-to-back fetch with a 1-cycle memory, plus the wrapping RESET_PC instance.
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'h0, tbl[i].rdy, tbl[i].idr);
            check("tbl_req", imem_req, tbl[i].exp_req);
            check("tbl_addr", imem_addr, tbl[i].exp_addr);
            check("tbl_valid", ir_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                check("tbl_ir_pc", ir_pc, tbl[i].exp_pc);
                check("tbl_ir", ir, instr_of(tbl[i].exp_pc));
            end
            if (i < 3) check("wrap_addr", u2_addr, u2_exp[i]);
            finish();
        end

        // Request at 0x10 held while IMEM is not ready.
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b1);
            check("hold_req", imem_req, 1'b1);
            check("hold_addr", imem_addr, 32'h10);
            finish();
        end
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        check("hold_release_addr", imem_addr, 32'h10);
        finish();
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        check("post_hold_addr", imem_addr, 32'h14);
        finish();

        // Decode stalled: credits stop requests after exactly FIFO_DEPTH accepts.
        do_reset();
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b0);
            if (imem_req && imem_rdy) n_acc++;
            finish();
        end
        check("full_accepts", n_acc, 4);
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        check("full_req_off", imem_req, 1'b0);
        check("full_head_pc", ir_pc, 32'h0);
        finish();
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b1);
            if (imem_req) found = 1'b1;
            finish();
        end
        check("full_resume", found, 1'b1);

        // Redirect with two requests in flight: both responses discarded.
        do_reset();
        lat_min = 4;
        lat_max = 4;
        apply(1'b1, 32'h20, 1'b1, 1'b1);
        check("redir_req_forced", imem_req, 1'b0);
        finish();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b1);
            finish();
        end
        apply(1'b1, 32'h100, 1'b1, 1'b1);
        finish();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b1);
            if (ir_valid) begin
                found = 1'b1;
                check("redir_first_pc", ir_pc, 32'h100);
            end
            finish();
        end
        check("redir_delivered", found, 1'b1);

        // Redirect coinciding with the response for 0x20 while 0x24 is outstanding.
        do_reset();
        apply(1'b1, 32'h20, 1'b1, 1'b1);
        finish();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                found = 1'b1;
                apply(1'b1, 32'h200, 1'b1, 1'b1);
                check("same_cycle_valid", imem_valid, 1'b1);
            end else begin
                apply(1'b0, 32'h0, 1'b1, 1'b1);
            end
            finish();
        end
        check("same_cycle_hit", found, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b1);
            if (ir_valid) begin
                found = 1'b1;
                check("same_cycle_first_pc", ir_pc, 32'h200);
            end
            finish();
        end
        check("same_cycle_delivered", found, 1'b1);

        // Response with nothing outstanding is ignored.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        spur = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        finish();
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        check("spurious_no_ir", ir_valid, 1'b0);
        check("spurious_req", imem_req, 1'b1);
        finish();

        // Asynchronous reset in the middle of a running stream.
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b1);
            finish();
        end
        check("pre_reset_valid", ir_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ir_valid", ir_valid, 1'b0);
        check("async_rst_stall", stall, 1'b1);
        check("async_rst_req", imem_req, 1'b0);
        @(negedge clk);
        do_reset();

        // Randomized traffic against the reference model.
        lat_min = 1;
        lat_max = 3;
        for (int k = 0; k < 2000; k++) begin
            logic [31:0] rpc;
            bit          rv;
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            spur = (pend.size() == 0 && mo.size() == 0 && $urandom_range(0, 15) == 0);
            apply(rv, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            finish();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
